// File: rtl/fetch_queue_pkg.sv
// Shared types and sizing helpers for the instruction-fetch queue.
package fetch_queue_pkg;

   localparam int unsigned INST_W = 32;

   typedef logic [INST_W-1:0] inst_t;

   // Width of a counter that must hold every value 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return unsigned'($clog2(depth + 1));
   endfunction

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? unsigned'($clog2(depth)) : 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries with push, pop and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter  int unsigned DEPTH   = 4,
   parameter  type         entry_t = logic [63:0],
   localparam int unsigned CW      = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  entry_t        i_data,
   input  logic          i_pop,
   input  logic          i_flush,
   output entry_t        o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   localparam int unsigned PW = ptr_w(DEPTH);

   entry_t        r_mem [DEPTH];
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [CW-1:0] r_count;

   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full buffer is legal only when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // NOTE: state updates use <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_pop)  r_rd <= r_rd + PW'(1);
         if (w_do_push) r_wr <= r_wr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; a slot is only read after it was written, and the top masks id_* while empty.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr] <= i_data;
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      i_push |-> (!o_full || w_do_pop || i_flush));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, credit-limited in-order requests, response queue, redirect flush.
// Define FETCHQ_BYPASS_EN to let a response reach ID in the same cycle when the queue is empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_inst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [31:0]     id_inst,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4
);

   localparam int unsigned     CW         = cnt_w(DEPTH);
   localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   typedef struct packed {
      inst_t           inst;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_resp_pc;
   logic [CW-1:0]   r_outst;
   logic [CW-1:0]   r_drop;

   logic [CW-1:0]   w_count;
   logic            w_full;
   logic            w_empty;
   fetch_entry_t    w_head;
   fetch_entry_t    w_resp_entry;
   fetch_entry_t    w_id_entry;
   logic            w_credit_ok;
   logic            w_req_fire;
   logic            w_resp_keep;
   logic            w_resp_drop;
   logic            w_bypass;
   logic            w_push;
   logic            w_fifo_pop;
   logic [CW-1:0]   w_outst_next;
   logic [XLEN-1:0] w_redirect_pc;

   // Outstanding requests plus queued entries never exceed DEPTH, so every response has a slot.
   assign w_credit_ok    = ({1'b0, r_outst} + {1'b0, w_count}) < CREDIT_MAX;
   assign imem_req_valid = rst && w_credit_ok && !redirect_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   assign w_resp_drop    = imem_resp_valid && (r_drop != '0);
   assign w_resp_keep    = imem_resp_valid && (r_drop == '0);
   assign w_resp_entry   = '{inst: imem_resp_inst, pc: r_resp_pc};
   assign w_outst_next   = r_outst + CW'(w_req_fire) - CW'(imem_resp_valid);
   assign w_redirect_pc  = redirect_pc & ~XLEN'(3);

`ifdef FETCHQ_BYPASS_EN
   assign w_bypass = rst && w_empty && w_resp_keep && !redirect_valid;
`else
   assign w_bypass = 1'b0;
`endif

   assign id_valid    = !w_empty || w_bypass;
   assign w_id_entry  = w_bypass ? w_resp_entry : w_head;
   assign id_inst     = id_valid ? w_id_entry.inst : '0;
   assign id_pc       = id_valid ? w_id_entry.pc : '0;
   assign id_pc_plus4 = id_valid ? (w_id_entry.pc + PC_STEP) : '0;

   assign w_fifo_pop  = id_ready && !w_empty;
   // A bypassed response that ID takes immediately never occupies a slot.
   assign w_push      = w_resp_keep && !(w_bypass && id_ready);

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_resp_entry),
      .i_pop   (w_fifo_pop),
      .i_flush (redirect_valid),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_outst    <= '0;
         r_drop     <= '0;
      end else begin
         r_outst <= w_outst_next;
         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            // Every request still in flight after this edge belongs to the abandoned stream.
            r_drop     <= w_outst_next;
         end else begin
            if (w_req_fire)  r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_resp_keep) r_resp_pc  <= r_resp_pc + PC_STEP;
            if (w_resp_drop) r_drop     <= r_drop - CW'(1);
         end
      end
   end

   a_resp_has_credit: assert property (@(posedge clk) disable iff (!rst)
      imem_resp_valid |-> (r_outst != '0));

   a_drop_bounded: assert property (@(posedge clk) disable iff (!rst)
      r_drop <= r_outst);

   a_full_blocks_req: assert property (@(posedge clk) disable iff (!rst)
      w_full |-> !imem_req_valid);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order streaming, stall/backpressure, redirect flush, PC wrap.
// Build with FETCHQ_BYPASS_EN to check the zero-latency response path.
module tb_fetch_queue;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

`ifdef FETCHQ_BYPASS_EN
   localparam int RESP_TO_ID = 0;
`else
   localparam int RESP_TO_ID = 1;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_req_valid;
   logic            imem_req_ready = 1'b0;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid = 1'b0;
   logic [31:0]     imem_resp_inst = '0;
   logic            redirect_valid = 1'b0;
   logic [XLEN-1:0] redirect_pc = '0;
   logic            id_valid;
   logic            id_ready = 1'b0;
   logic [31:0]     id_inst;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_pc_plus4;

   always #5 clk = ~clk;

   fetch_queue #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC ('0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_inst  (imem_resp_inst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_inst         (id_inst),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] mem_inst(input logic [31:0] a);
      return {a[15:0], 16'h0013};
   endfunction

   // Memory model: in-order, fixed latency, optionally frozen.
   logic [31:0] pend_addr [$];
   int          pend_cyc  [$];
   int          mem_lat  = 1;
   bit          mem_hold = 1'b0;

   logic [31:0] req_log  [$];
   int          req_cyc  [$];
   logic [31:0] pop_pc   [$];
   logic [31:0] pop_inst [$];
   logic [31:0] pop_p4   [$];
   int          pop_cyc  [$];
   logic [31:0] exp_pc   [$];

   int          cyc = 0;
   int          first_resp_cyc = -1;
   bit          s_req_valid;
   bit          s_id_valid;
   bit          drv_id_ready = 1'b0;
   bit          drv_redirect = 1'b0;
   logic [31:0] drv_redirect_pc = '0;

   task automatic tick();
      bit          fire;
      bit          resp;
      logic [31:0] addr;
      @(negedge clk);
      imem_req_ready = 1'b1;
      id_ready       = drv_id_ready;
      redirect_valid = drv_redirect;
      redirect_pc    = drv_redirect_pc;
      if (!mem_hold && pend_addr.size() > 0 && cyc >= pend_cyc[0] + mem_lat) begin
         imem_resp_valid = 1'b1;
         imem_resp_inst  = mem_inst(pend_addr[0]);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_inst  = '0;
      end
      #1;
      s_req_valid = imem_req_valid;
      s_id_valid  = id_valid;
      resp        = imem_resp_valid;
      fire        = imem_req_valid && imem_req_ready;
      addr        = imem_req_addr;
      if (fire) begin
         req_log.push_back(addr);
         req_cyc.push_back(cyc);
      end
      if (resp && first_resp_cyc < 0) first_resp_cyc = cyc;
      if (id_valid && id_ready) begin
         pop_pc.push_back(id_pc);
         pop_inst.push_back(id_inst);
         pop_p4.push_back(id_pc_plus4);
         pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      if (resp) begin
         void'(pend_addr.pop_front());
         void'(pend_cyc.pop_front());
      end
      if (fire) begin
         pend_addr.push_back(addr);
         pend_cyc.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   // Resets DUT and memory model together; optionally checks outputs while reset is held.
   task automatic do_reset(input string tag, input bit chk);
      @(negedge clk);
      rst             = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_inst  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      id_ready        = 1'b0;
      drv_id_ready    = 1'b0;
      drv_redirect    = 1'b0;
      drv_redirect_pc = '0;
      mem_hold        = 1'b0;
      mem_lat         = 1;
      pend_addr.delete(); pend_cyc.delete();
      req_log.delete();   req_cyc.delete();
      pop_pc.delete();    pop_inst.delete(); pop_p4.delete(); pop_cyc.delete();
      first_resp_cyc  = -1;
      #1;
      check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check({tag, "_id_valid"},  32'(id_valid), 32'd0);
      if (chk) begin
         check({tag, "_req_addr"}, imem_req_addr, 32'h0);
         check({tag, "_id_inst"},  id_inst, 32'h0);
         check({tag, "_id_pc"},    id_pc, 32'h0);
         check({tag, "_id_pc_p4"}, id_pc_plus4, 32'h0);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      cyc = 1;
   endtask

   // Compares the handshaken ID stream against exp_pc (pc, instruction and pc+4 per entry).
   task automatic check_pop_seq(input string tag);
      check({tag, "_enough_pops"}, 32'(pop_pc.size() >= exp_pc.size()), 32'd1);
      for (int i = 0; i < exp_pc.size() && i < pop_pc.size(); i++) begin
         check($sformatf("%s_pc%0d", tag, i),   pop_pc[i],   exp_pc[i]);
         check($sformatf("%s_inst%0d", tag, i), pop_inst[i], mem_inst(exp_pc[i]));
         check($sformatf("%s_p4_%0d", tag, i),  pop_p4[i],   exp_pc[i] + 32'd4);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_req_stall;

      // 1: streaming from reset with 1-cycle memory and ID always ready.
      do_reset("rst0", 1'b1);
      drv_id_ready = 1'b1;
      run(10);
      check("t1_first_req_addr", req_log[0], 32'h0);
      check("t1_first_req_cyc", 32'(req_cyc[0]), 32'd1);
      check("t1_req_addr4", req_log[4], 32'h10);
      check("t1_first_pop_cyc", 32'(pop_cyc[0]), 32'(2 + RESP_TO_ID));
      check("t1_resp_to_id", 32'(pop_cyc[0] - first_resp_cyc), 32'(RESP_TO_ID));
      check("t1_no_gaps", 32'(pop_cyc[5] - pop_cyc[0]), 32'd5);
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
      check_pop_seq("t1");

      // 2: ID stalls for 10 cycles, then drains; reset asserted mid-stream.
      do_reset("rst1", 1'b0);
      drv_id_ready = 1'b0;
      run(10);
      n_req_stall = req_log.size();
      check("t2_reqs_during_stall", 32'(n_req_stall), 32'd4);
      check("t2_req_valid_full", 32'(s_req_valid), 32'd0);
      check("t2_id_valid_stalled", 32'(s_id_valid), 32'd1);
      check("t2_no_pops_stalled", 32'(pop_pc.size()), 32'd0);
      drv_id_ready = 1'b1;
      run(8);
      check("t2_drain_start", 32'(pop_cyc[0]), 32'd11);
      check("t2_drain_count", 32'(pop_pc.size()), 32'd8);
      check("t2_drain_no_gaps", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
      check_pop_seq("t2");

      // 3: redirect to an unaligned target with two responses held in flight.
      do_reset("rst2", 1'b0);
      drv_id_ready = 1'b1;
      mem_hold     = 1'b1;
      run(2);
      drv_redirect    = 1'b1;
      drv_redirect_pc = 32'h103;
      tick();
      check("t3_no_req_in_redirect", 32'(s_req_valid), 32'd0);
      check("t3_reqs_before", 32'(req_log.size()), 32'd2);
      drv_redirect = 1'b0;
      mem_hold     = 1'b0;
      run(9);
      check("t3_target_addr", req_log[2], 32'h100);
      check("t3_target_cyc", 32'(req_cyc[2]), 32'd4);
      exp_pc = '{32'h100, 32'h104, 32'h108};
      check_pop_seq("t3");

      // 4: redirect coinciding with a kept response and a pop, 2-cycle memory.
      do_reset("rst3", 1'b0);
      mem_lat      = 2;
      drv_id_ready = 1'b1;
      run(4);
      drv_redirect    = 1'b1;
      drv_redirect_pc = 32'h200;
      tick();
      drv_redirect = 1'b0;
      tick();
      check("t4_empty_after_redirect", 32'(s_id_valid), 32'd0);
      check("t4_target_addr", req_log[4], 32'h200);
      check("t4_target_cyc", 32'(req_cyc[4]), 32'd6);
      run(8);
      exp_pc = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h208};
      check_pop_seq("t4");

      // 5: fetch PC wraps from the top of the address space.
      do_reset("rst4", 1'b0);
      drv_id_ready    = 1'b1;
      drv_redirect    = 1'b1;
      drv_redirect_pc = 32'hFFFF_FFF8;
      tick();
      drv_redirect = 1'b0;
      run(8);
      check("t5_req0", req_log[0], 32'hFFFF_FFF8);
      check("t5_req1", req_log[1], 32'hFFFF_FFFC);
      check("t5_req_wrap", req_log[2], 32'h0);
      exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
      check_pop_seq("t5");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
